// File: rtl/hsv_core_commit_sink.sv
// -----------------------------------------------------------------------------
// hsv_core_commit_sink
//
// Commit stage of the core. This block receives result beats from the
// execution unit and retires them in order into the register file.
//
// Non-exception beats:
//   - Write the register file through a registered write port.
//   - Advance the retired-instruction counter.
//
// Exception beats and external redirect requests:
//   - Start a flush handshake with the execution unit (flush_req/flush_ack).
//   - Then hand a redirect target to fetch.
//
// Ports
//   clk_core, rst_core       core clock; synchronous active-low reset
//   in_valid/in_ready        result beat handshake
//   in_pc/in_rd/in_result    beat payload (PC, destination, data)
//   in_exception             beat raises an exception
//   flush_req/flush_ack      flush handshake with the execution unit
//   ext_flush_valid/_pc      external redirect request and its target
//   ext_flush_ready          external request accepted this cycle
//   redirect_valid/_pc       redirect to fetch
//   redirect_ready           fetch accepts the redirect
//   rf_we/rf_waddr/rf_wdata  register file write port (registered)
//   epc                      PC of the last committed exception beat
//   retired_count            committed non-exception beats (wraps)
//   flush_error              sticky: flush_ack did not arrive in time
// -----------------------------------------------------------------------------
module hsv_core_commit_sink #(
    parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
    parameter int unsigned FLUSH_TIMEOUT = 16,
    parameter int unsigned COUNT_W       = 64
) (
    input  logic               clk_core,
    input  logic               rst_core,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_pc,
    input  logic [4:0]         in_rd,
    input  logic [31:0]        in_result,
    input  logic               in_exception,

    output logic               flush_req,
    input  logic               flush_ack,

    input  logic               ext_flush_valid,
    input  logic [31:0]        ext_flush_pc,
    output logic               ext_flush_ready,

    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    input  logic               redirect_ready,

    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [31:0]        rf_wdata,

    output logic [31:0]        epc,
    output logic [COUNT_W-1:0] retired_count,
    output logic               flush_error
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    // The timeout counter saturates at FLUSH_TIMEOUT. The error flag is set
    // on the edge where the count reaches FLUSH_TIMEOUT, which is the edge
    // where the old count equals TMO_LAST.
    localparam logic [15:0] TMO_MAX  = 16'(FLUSH_TIMEOUT);
    localparam logic [15:0] TMO_LAST = 16'(FLUSH_TIMEOUT - 1);
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t               state_reg, state_next;
    logic [31:0]          target_reg, target_next;
    logic [31:0]          epc_reg, epc_next;
    logic [15:0]          tmo_reg, tmo_next;
    logic                 flush_error_reg, flush_error_next;
    logic                 flush_req_reg, flush_req_next;
    logic                 redirect_valid_reg, redirect_valid_next;
    logic                 rf_we_reg, rf_we_next;
    logic [4:0]           rf_waddr_reg, rf_waddr_next;
    logic [31:0]          rf_wdata_reg, rf_wdata_next;
    logic [COUNT_W-1:0]   count_reg, count_next;

    logic                 in_run;
    logic                 beat_fire;
    logic                 beat_commit;
    logic                 beat_trap;
    logic                 ext_accept;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    // in_ready is a function of state only, so the execution unit never sees
    // ready depend on its own valid.
    assign in_run      = (state_reg == ST_RUN);
    assign in_ready    = in_run;
    assign beat_fire   = in_valid & in_run;
    assign beat_commit = beat_fire & ~in_exception;
    assign beat_trap   = beat_fire & in_exception;

    // An exception beat presented this cycle blocks the external request.
    // The trap then wins, and the external request waits until RUN resumes.
    assign ext_flush_ready = in_run & ~(in_valid & in_exception);
    assign ext_accept      = ext_flush_valid & ext_flush_ready;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        target_next      = target_reg;
        epc_next         = epc_reg;
        tmo_next         = tmo_reg;
        flush_error_next = flush_error_reg;
        rf_we_next       = 1'b0;
        rf_waddr_next    = rf_waddr_reg;
        rf_wdata_next    = rf_wdata_reg;
        count_next       = count_reg;

        // A committing beat always retires, even when an external request is
        // accepted in the same cycle. The beat is older than the redirect.
        if (beat_commit) begin
            rf_we_next    = (in_rd != 5'd0);
            rf_waddr_next = in_rd;
            rf_wdata_next = in_result;
            count_next    = count_reg + COUNT_ONE;
        end

        case (state_reg)
            ST_RUN: begin
                if (beat_trap) begin
                    epc_next    = in_pc;
                    target_next = TRAP_VECTOR;
                    tmo_next    = 16'd0;
                    state_next  = ST_FLUSH;
                end else if (ext_accept) begin
                    target_next = ext_flush_pc;
                    tmo_next    = 16'd0;
                    state_next  = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                if (flush_ack) begin
                    tmo_next   = 16'd0;
                    state_next = ST_REDIRECT;
                end else begin
                    if (tmo_reg != TMO_MAX) begin
                        tmo_next = tmo_reg + 16'd1;
                    end
                    // Timing out does not abort the flush. The error is only
                    // flagged, and the FSM keeps waiting for the ack.
                    if (tmo_reg >= TMO_LAST) begin
                        flush_error_next = 1'b1;
                    end
                end
            end

            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase

        // Handshake outputs are registered copies of the upcoming state. They
        // therefore change together with the state and never glitch.
        flush_req_next      = (state_next == ST_FLUSH);
        redirect_valid_next = (state_next == ST_REDIRECT);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_core) begin
        if (!rst_core) begin
            state_reg          <= ST_RUN;
            target_reg         <= 32'd0;
            epc_reg            <= 32'd0;
            tmo_reg            <= 16'd0;
            flush_error_reg    <= 1'b0;
            flush_req_reg      <= 1'b0;
            redirect_valid_reg <= 1'b0;
            rf_we_reg          <= 1'b0;
            rf_waddr_reg       <= 5'd0;
            rf_wdata_reg       <= 32'd0;
            count_reg          <= '0;
        end else begin
            state_reg          <= state_next;
            target_reg         <= target_next;
            epc_reg            <= epc_next;
            tmo_reg            <= tmo_next;
            flush_error_reg    <= flush_error_next;
            flush_req_reg      <= flush_req_next;
            redirect_valid_reg <= redirect_valid_next;
            rf_we_reg          <= rf_we_next;
            rf_waddr_reg       <= rf_waddr_next;
            rf_wdata_reg       <= rf_wdata_next;
            count_reg          <= count_next;
        end
    end

    // The target register is loaded only when the FSM enters FLUSH. It then
    // stays stable for the whole REDIRECT phase.
    assign redirect_pc    = target_reg;
    assign redirect_valid = redirect_valid_reg;
    assign flush_req      = flush_req_reg;
    assign flush_error    = flush_error_reg;
    assign epc            = epc_reg;
    assign rf_we          = rf_we_reg;
    assign rf_waddr       = rf_waddr_reg;
    assign rf_wdata       = rf_wdata_reg;
    assign retired_count  = count_reg;

endmodule

// File: tb/tb_hsv_core_commit_sink.sv
// -----------------------------------------------------------------------------
// tb_hsv_core_commit_sink
//
// Directed bench for hsv_core_commit_sink, using default parameters.
//
// Stimulus is applied 1 ns after each rising edge. Registered outputs are
// checked at that same point, after the edge they follow.
// -----------------------------------------------------------------------------
module tb_hsv_core_commit_sink;

    logic        clk_core = 1'b0;
    logic        rst_core;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_exception;
    logic        flush_req;
    logic        flush_ack;
    logic        ext_flush_valid;
    logic [31:0] ext_flush_pc;
    logic        ext_flush_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] epc;
    logic [63:0] retired_count;
    logic        flush_error;

    int total = 0;
    int bad   = 0;

    hsv_core_commit_sink dut (
        .clk_core        (clk_core),
        .rst_core        (rst_core),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_rd           (in_rd),
        .in_result       (in_result),
        .in_exception    (in_exception),
        .flush_req       (flush_req),
        .flush_ack       (flush_ack),
        .ext_flush_valid (ext_flush_valid),
        .ext_flush_pc    (ext_flush_pc),
        .ext_flush_ready (ext_flush_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .redirect_ready  (redirect_ready),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .epc             (epc),
        .retired_count   (retired_count),
        .flush_error     (flush_error)
    );

    always #5 clk_core = ~clk_core;

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            $display("check %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_core        = 1'b0;
        in_valid        = 1'b0;
        in_pc           = 32'd0;
        in_rd           = 5'd0;
        in_result       = 32'd0;
        in_exception    = 1'b0;
        flush_ack       = 1'b0;
        ext_flush_valid = 1'b0;
        ext_flush_pc    = 32'd0;
        redirect_ready  = 1'b0;

        // ---- reset ----
        tick();
        tick();
        rst_core = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_flush_req", flush_req, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_count", retired_count, 0);
        chk("rst_epc", epc, 0);
        chk("rst_flush_error", flush_error, 0);
        chk("rst_ext_ready", ext_flush_ready, 1);

        // ---- back-to-back beats ----
        in_valid = 1'b1; in_pc = 32'h10; in_rd = 5'd5; in_result = 32'hDEADBEEF;
        tick();
        chk("b1_we", rf_we, 1);
        chk("b1_waddr", rf_waddr, 5);
        chk("b1_wdata", rf_wdata, 32'hDEADBEEF);
        chk("b1_count", retired_count, 1);
        in_pc = 32'h14; in_rd = 5'd0; in_result = 32'd7;
        tick();
        in_valid = 1'b0;
        chk("b2_we_rd0", rf_we, 0);
        chk("b2_count", retired_count, 2);
        tick();
        chk("idle_we", rf_we, 0);
        chk("idle_count", retired_count, 2);

        // ---- exception beat ----
        in_valid = 1'b1; in_exception = 1'b1; in_pc = 32'h40; in_rd = 5'd9; in_result = 32'h55;
        #1;
        chk("exc_ext_ready_blocked", ext_flush_ready, 0);
        tick();
        in_valid = 1'b0; in_exception = 1'b0;
        chk("exc_no_write", rf_we, 0);
        chk("exc_no_count", retired_count, 2);
        chk("exc_epc", epc, 32'h40);
        chk("exc_flush_req", flush_req, 1);
        chk("exc_in_ready", in_ready, 0);
        chk("exc_no_redirect_yet", redirect_valid, 0);
        // The ack arrives one cycle after flush_req rises. A beat offered
        // during FLUSH must not be consumed.
        flush_ack = 1'b1;
        in_valid = 1'b1; in_rd = 5'd7; in_result = 32'h77;
        tick();
        flush_ack = 1'b0; in_valid = 1'b0;
        chk("exc_flush_beat_dropped_we", rf_we, 0);
        chk("exc_flush_beat_dropped_cnt", retired_count, 2);
        chk("exc_flush_req_drop", flush_req, 0);
        chk("exc_redirect_valid", redirect_valid, 1);
        chk("exc_redirect_pc", redirect_pc, 32'h100);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("exc_redirect_done", redirect_valid, 0);
        chk("exc_run_in_ready", in_ready, 1);

        // ---- normal beat together with an external flush ----
        in_valid = 1'b1; in_pc = 32'h50; in_rd = 5'd3; in_result = 32'h33;
        ext_flush_valid = 1'b1; ext_flush_pc = 32'h2000;
        #1;
        chk("mix_ext_ready", ext_flush_ready, 1);
        tick();
        in_valid = 1'b0; ext_flush_valid = 1'b0;
        chk("mix_we", rf_we, 1);
        chk("mix_waddr", rf_waddr, 3);
        chk("mix_wdata", rf_wdata, 32'h33);
        chk("mix_count", retired_count, 3);
        chk("mix_flush_req", flush_req, 1);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("mix_redirect_valid", redirect_valid, 1);
        chk("mix_redirect_pc", redirect_pc, 32'h2000);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("mix_back_to_run", in_ready, 1);

        // ---- exception beat together with an external flush ----
        in_valid = 1'b1; in_exception = 1'b1; in_pc = 32'h60;
        ext_flush_valid = 1'b1; ext_flush_pc = 32'h3000;
        #1;
        chk("prec_ext_ready", ext_flush_ready, 0);
        tick();
        in_valid = 1'b0; in_exception = 1'b0;
        chk("prec_epc", epc, 32'h60);
        chk("prec_flush_req", flush_req, 1);
        chk("prec_ext_ready_flush", ext_flush_ready, 0);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("prec_redirect_pc", redirect_pc, 32'h100);
        chk("prec_ext_ready_redir", ext_flush_ready, 0);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("prec_ext_ready_run", ext_flush_ready, 1);
        tick();
        ext_flush_valid = 1'b0;
        chk("prec_ext_flush_req", flush_req, 1);
        chk("prec_count_kept", retired_count, 3);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("prec_ext_redirect_pc", redirect_pc, 32'h3000);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;

        // ---- flush_ack timeout ----
        ext_flush_valid = 1'b1; ext_flush_pc = 32'h4000;
        tick();
        ext_flush_valid = 1'b0;
        repeat (15) tick();
        chk("tmo_not_yet", flush_error, 0);
        tick();
        chk("tmo_error_set", flush_error, 1);
        repeat (5) tick();
        chk("tmo_error_sticky", flush_error, 1);
        chk("tmo_still_flushing", flush_req, 1);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("tmo_redirect_valid", redirect_valid, 1);
        chk("tmo_redirect_pc", redirect_pc, 32'h4000);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("tmo_error_after_run", flush_error, 1);
        chk("tmo_run_in_ready", in_ready, 1);

        // ---- reset during REDIRECT ----
        in_valid = 1'b1; in_exception = 1'b1; in_pc = 32'h80;
        tick();
        in_valid = 1'b0; in_exception = 1'b0;
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("rr_redirect_valid", redirect_valid, 1);
        rst_core = 1'b0;
        tick();
        rst_core = 1'b1;
        chk("rr_redirect_cleared", redirect_valid, 0);
        chk("rr_in_ready", in_ready, 1);
        chk("rr_count", retired_count, 0);
        chk("rr_epc", epc, 0);
        chk("rr_flush_error", flush_error, 0);
        chk("rr_redirect_pc", redirect_pc, 0);
        repeat (3) tick();
        chk("rr_no_late_redirect", redirect_valid, 0);
        chk("rr_no_flush_req", flush_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
